sort_result_capture: RTL and testbench
======================================

Name: sort_result_capture

Overview:
- Sits directly downstream of the two-layer sort ring and consumes its sorted serial result stream (data_out) once the finishing layer raises sort_finish.
- Deserializes a fixed-length frame of words and checks that the words arrive in non-decreasing order.
- Compresses the frame into a CRC-16 signature and reports done/pass/timeout status to the self-test controller.

Parameters:
- WIDTH, 8, bits per sorted word.
- N_WORDS, 16, words per result frame.
- TIMEOUT, 1024, maximum cycles to wait for the start bit after arming.
- SIG_POLY, 16'h1021, CRC-16 polynomial used for the signature.

Ports:
- t_clk  in  1  single clock; all state samples on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sort_finish  in  1  arm level from the upstream sort layer.
- data_in  in  1  serial result stream, start bit followed by MSB-first words.
- word_valid  out  1  one-cycle pulse per completed word.
- word_out  out  WIDTH  last completed word; held between pulses.
- word_idx  out  $clog2(N_WORDS)  index of word_out within the frame.
- done  out  1  frame finished or timed out; sticky.
- pass  out  1  done with zero order errors and no timeout.
- timeout  out  1  start bit not seen within TIMEOUT cycles.
- order_err_cnt  out  8  count of order violations, saturating at 255.
- signature  out  16  CRC over all captured data bits.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0, except signature=16'hFFFF. The internal sort_finish_q resets to 1, so a level that is already high at reset release does not arm the block; a fresh rising edge is required.
- IDLE:
  - A rising edge (sort_finish=1, sort_finish_q=0) clears done, pass, timeout and order_err_cnt, loads signature=16'hFFFF and the wait counter=0, then moves to WAIT_START.
  - Otherwise all status is held.
- WAIT_START:
  - data_in=1 → CAPTURE. The start bit is not part of the signature.
  - Wait counter reaching TIMEOUT-1 with no start bit → DONE with timeout=1, pass=0.
- CAPTURE:
  - Bit counter runs 0..WIDTH-1 and word counter runs 0..N_WORDS-1. Each cycle one data bit shifts into the word register, MSB first.
  - Signature update every data bit: fb = signature[15]^data_in; signature = {signature[14:0],1'b0} ^ (fb ? SIG_POLY : 0).
  - When bit WIDTH-1 is sampled, the next cycle shows word_valid=1, word_out=assembled word and word_idx=word counter.
  - Word 0 is never compared. For word k>0, word_k < word_(k-1) increments order_err_cnt (saturating at 255); equal words are legal.
  - Words are back-to-back with no gap and no per-word start bit.
  - After the last bit of word N_WORDS-1 → DONE.
- DONE:
  - done=1 and pass=(order_err_cnt==0 && !timeout), asserted in the same cycle as the final word_valid.
  - sort_finish=0 → IDLE with all status held.
- Abort: sort_finish falling during WAIT_START or CAPTURE → IDLE. done stays 0 and the partial counters are discarded. signature and order_err_cnt keep their partial values and are not reported as pass.
- Simultaneous events: a falling sort_finish in the same cycle as the last data bit → abort wins, done stays 0. A rising edge is only detected in IDLE, so re-arming requires sort_finish to go low and then high again.
- Latency: start bit sampled at cycle s. Word k's last bit is sampled at s+(k+1)*WIDTH, and its word_valid appears one cycle later. done rises at s+N_WORDS*WIDTH+1.

Decomposition:
- Shared package sort_cap_pkg:
  - state enum {IDLE, WAIT_START, CAPTURE, DONE};
  - constants SIG_INIT=16'hFFFF and SIG_POLY_DEFAULT=16'h1021;
  - ERR_CNT_W=8.
- One sub-module, crc16_serial: ports clk, rst_n, init, en, bit_in, sig[15:0]. It holds the signature register and update equation.
- The top module holds the FSM, counters, deserializer and comparator.

Test Plan:
- Reset held, sort_finish=1, then release with no new edge → stays IDLE, all outputs 0, signature=16'hFFFF.
- Rising edge, start bit, 16 ascending words 0x00..0x0F → 16 word_valid pulses with word_idx 0..15, order_err_cnt=0, done=1 and pass=1 at s+129, signature equals the bench CRC model.
- Frame 0x05,0x03,0x03,0x01,0x10… (rest ascending) → order_err_cnt=2 (the repeated 0x03 is legal), done=1, pass=0.
- Arm and keep data_in=0 for 1024 cycles → timeout=1, done=1, pass=0; drop sort_finish → IDLE with status held; re-arm → status cleared.
- Drop sort_finish after word 5 of a frame → no done, state IDLE; re-arm and send a full ascending frame → pass=1.
- Frame of 256 alternating 0xFF/0x00 pairs with N_WORDS=512 → order_err_cnt saturates at 255.

Source files
------------

// File: rtl/sort_cap_pkg.sv
// rtl/sort_cap_pkg.sv - shared types and constants for the sort result capture block
package sort_cap_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } cap_state_e;

    localparam logic [15:0] SIG_INIT         = 16'hFFFF;
    localparam logic [15:0] SIG_POLY_DEFAULT = 16'h1021;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Saturating increment for the order-error counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sort_result_capture_if.sv
// rtl/sort_result_capture_if.sv - result stream input and status output bundle
//
// master: upstream sort ring / self-test side (drives sort_finish, data_in)
// slave : capture block (drives word and frame status)
//   sort_finish    arm level from the sort layer
//   data_in        serial stream: start bit then MSB-first words
//   word_valid     one-cycle pulse per completed word
//   word_out       last completed word
//   word_idx       index of word_out in the frame
//   done/pass      frame finished / finished cleanly
//   timeout        no start bit within the wait window
//   order_err_cnt  saturating count of order violations
//   signature      CRC-16 over captured data bits
interface sort_result_capture_if
    import sort_cap_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N_WORDS = 16
);
    logic                       sort_finish;
    logic                       data_in;
    logic                       word_valid;
    logic [WIDTH-1:0]           word_out;
    logic [$clog2(N_WORDS)-1:0] word_idx;
    logic                       done;
    logic                       pass;
    logic                       timeout;
    logic [ERR_CNT_W-1:0]       order_err_cnt;
    logic [15:0]                signature;

    modport master (
        output sort_finish, data_in,
        input  word_valid, word_out, word_idx, done, pass, timeout,
               order_err_cnt, signature
    );

    modport slave (
        input  sort_finish, data_in,
        output word_valid, word_out, word_idx, done, pass, timeout,
               order_err_cnt, signature
    );
endinterface

// File: rtl/crc16_serial.sv
// rtl/crc16_serial.sv - bit-serial CRC-16 signature register, MSB-first
//
// clk, rst_n  clock and asynchronous active-low reset
// init        reload the signature with INIT (wins over en)
// en          fold bit_in into the signature this cycle
// bit_in      data bit
// sig         current signature
module crc16_serial
    import sort_cap_pkg::*;
#(
    parameter logic [15:0] POLY = SIG_POLY_DEFAULT,
    parameter logic [15:0] INIT = SIG_INIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] sig
);
    logic fb;

    assign fb = sig[15] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= INIT;
        end else if (init) begin
            sig <= INIT;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
    end
endmodule

// File: rtl/sort_result_capture.sv
// rtl/sort_result_capture.sv - deserialize, order-check and sign a sorted result frame
//
// t_clk   single clock, rising edge
// rst_n   asynchronous active-low reset
// bus     slave side of sort_result_capture_if (sort_finish/data_in in,
//         word and frame status out)
module sort_result_capture
    import sort_cap_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int          N_WORDS  = 16,
    parameter int          TIMEOUT  = 1024,
    parameter logic [15:0] SIG_POLY = SIG_POLY_DEFAULT
) (
    input logic                  t_clk,
    input logic                  rst_n,
    sort_result_capture_if.slave bus
);
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W  = $clog2(N_WORDS);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    cap_state_e state, state_next;

    logic                 sort_finish_q;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     word_cnt;
    logic [WIDTH-1:0]     shift_reg;
    logic [WIDTH-1:0]     assembled;
    logic [WIDTH-1:0]     word_out_q;
    logic [IDX_W-1:0]     word_idx_q;
    logic                 word_valid_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ERR_CNT_W-1:0] err_next;
    logic [15:0]          sig;

    logic arm_edge;
    logic last_bit;
    logic last_word;
    logic wait_expired;
    logic arm_fire;
    logic wait_step;
    logic bit_en;
    logic timeout_fire;
    logic word_fire;
    logic frame_end;

    // sort_finish_q resets high so a level already up at reset release is
    // not mistaken for a fresh arm request.
    assign arm_edge     = bus.sort_finish & ~sort_finish_q;
    assign last_bit     = (bit_cnt == BIT_W'(WIDTH - 1));
    assign last_word    = (word_cnt == IDX_W'(N_WORDS - 1));
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign assembled    = {shift_reg[WIDTH-2:0], bus.data_in};
    assign word_fire    = bit_en & last_bit;
    assign frame_end    = word_fire & last_word;

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A low sort_finish aborts WAIT_START/CAPTURE before any data bit or
    // start bit is considered, so abort beats a coincident last bit.
    always_comb begin
        state_next   = state;
        arm_fire     = 1'b0;
        wait_step    = 1'b0;
        bit_en       = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (arm_edge) begin
                    state_next = WAIT_START;
                    arm_fire   = 1'b1;
                end
            end
            WAIT_START: begin
                if (!bus.sort_finish) begin
                    state_next = IDLE;
                end else if (bus.data_in) begin
                    state_next = CAPTURE;
                end else if (wait_expired) begin
                    state_next   = DONE;
                    timeout_fire = 1'b1;
                end else begin
                    wait_step = 1'b1;
                end
            end
            CAPTURE: begin
                if (!bus.sort_finish) begin
                    state_next = IDLE;
                end else begin
                    bit_en = 1'b1;
                    if (last_bit && last_word) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.sort_finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word 0 has no predecessor; equal neighbours are legal.
    always_comb begin
        err_next = err_cnt;
        if (arm_fire) begin
            err_next = '0;
        end else if (word_fire && (word_cnt != '0) && (assembled < word_out_q)) begin
            err_next = sat_inc(err_cnt);
        end
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            sort_finish_q <= 1'b1;
            wait_cnt      <= '0;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            shift_reg     <= '0;
            word_out_q    <= '0;
            word_idx_q    <= '0;
            word_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            err_cnt       <= '0;
        end else begin
            sort_finish_q <= bus.sort_finish;
            word_valid_q  <= word_fire;
            err_cnt       <= err_next;

            if (arm_fire) begin
                wait_cnt  <= '0;
                bit_cnt   <= '0;
                word_cnt  <= '0;
                done_q    <= 1'b0;
                pass_q    <= 1'b0;
                timeout_q <= 1'b0;
            end

            if (wait_step) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (bit_en) begin
                shift_reg <= assembled;
                bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
                if (last_bit) begin
                    word_out_q <= assembled;
                    word_idx_q <= word_cnt;
                    word_cnt   <= last_word ? '0 : word_cnt + 1'b1;
                end
            end

            // pass uses err_next so the final word's comparison counts.
            if (frame_end) begin
                done_q <= 1'b1;
                pass_q <= (err_next == '0);
            end

            if (timeout_fire) begin
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
                pass_q    <= 1'b0;
            end
        end
    end

    crc16_serial #(
        .POLY (SIG_POLY),
        .INIT (SIG_INIT)
    ) u_crc (
        .clk    (t_clk),
        .rst_n  (rst_n),
        .init   (arm_fire),
        .en     (bit_en),
        .bit_in (bus.data_in),
        .sig    (sig)
    );

    assign bus.word_valid    = word_valid_q;
    assign bus.word_out      = word_out_q;
    assign bus.word_idx      = word_idx_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.order_err_cnt = err_cnt;
    assign bus.signature     = sig;
endmodule

// File: tb/tb_sort_result_capture.sv
// tb/tb_sort_result_capture.sv - self-checking bench for sort_result_capture
module tb_sort_result_capture;
    localparam int W  = 8;
    localparam int N1 = 16;
    localparam int N2 = 512;
    localparam int TO = 1024;

    typedef struct {
        logic [7:0] w;
        int         idx;
        int         cyc;
        bit         last;
    } exp_word_t;

    logic t_clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_pass   = 0;

    exp_word_t   q1[$];
    exp_word_t   q2[$];
    exp_word_t   e1, e2;
    logic [15:0] exp_sig[2];
    int          exp_err[2];
    bit          exp_pass[2];

    always #5 t_clk = ~t_clk;
    always @(posedge t_clk) cyc <= cyc + 1;

    sort_result_capture_if #(.WIDTH(W), .N_WORDS(N1)) bus1();
    sort_result_capture_if #(.WIDTH(W), .N_WORDS(N2)) bus2();

    sort_result_capture #(.WIDTH(W), .N_WORDS(N1), .TIMEOUT(TO), .SIG_POLY(16'h1021)) u_dut1 (
        .t_clk (t_clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    sort_result_capture #(.WIDTH(W), .N_WORDS(N2), .TIMEOUT(TO), .SIG_POLY(16'h1021)) u_dut2 (
        .t_clk (t_clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // CRC-16, init FFFF, poly 1021, MSB-first over every byte.
    function automatic logic [15:0] crc_bytes(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int j = 7; j >= 0; j--) begin
                c = {c[14:0], 1'b0} ^ (((c[15] ^ b[i][j]) == 1'b1) ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic int order_errs(input logic [7:0] b[$]);
        int e;
        e = 0;
        for (int i = 1; i < b.size(); i++) if (b[i] < b[i-1]) e++;
        return (e > 255) ? 255 : e;
    endfunction

    task automatic drive(input int sel, input logic sf, input logic d);
        @(posedge t_clk);
        #1;
        if (sel == 0) begin bus1.sort_finish = sf; bus1.data_in = d; end
        else          begin bus2.sort_finish = sf; bus2.data_in = d; end
    endtask

    // Arms, sends start bit and the words; abort_at >= 0 drops sort_finish
    // on that data bit index.
    task automatic send_frame(input int sel, input logic [7:0] words[$], input int abort_at);
        int        s;
        int        nbits;
        exp_word_t e;
        nbits = words.size() * W;
        drive(sel, 1'b0, 1'b0);
        drive(sel, 1'b1, 1'b0);
        drive(sel, 1'b1, 1'b1);
        s = cyc + 1;
        exp_sig[sel]  = crc_bytes(words);
        exp_err[sel]  = order_errs(words);
        exp_pass[sel] = (exp_err[sel] == 0);
        foreach (words[k]) begin
            if (abort_at < 0 || ((k + 1) * W - 1) < abort_at) begin
                e.w    = words[k];
                e.idx  = k;
                e.cyc  = s + (k + 1) * W;
                e.last = (k == words.size() - 1);
                if (sel == 0) q1.push_back(e); else q2.push_back(e);
            end
        end
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] wv;
            wv = words[i / W];
            if (i == abort_at) begin
                drive(sel, 1'b0, wv[W-1-(i%W)]);
                break;
            end
            drive(sel, 1'b1, wv[W-1-(i%W)]);
        end
        repeat (3) drive(sel, (abort_at < 0) ? 1'b1 : 1'b0, 1'b0);
        chk("words outstanding", (sel == 0) ? q1.size() : q2.size(), 0);
    endtask

    always @(negedge t_clk) begin
        if (rst_n) begin
            if (bus1.word_valid) begin
                if (q1.size() == 0) chk("dut1 unexpected word_valid", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    chk("dut1 word_out", bus1.word_out, e1.w);
                    chk("dut1 word_idx", bus1.word_idx, e1.idx);
                    chk("dut1 word cycle", cyc, e1.cyc);
                    chk("dut1 done with word", bus1.done, e1.last);
                    if (e1.last) begin
                        chk("dut1 pass", bus1.pass, exp_pass[0]);
                        chk("dut1 order_err_cnt", bus1.order_err_cnt, exp_err[0]);
                        chk("dut1 signature", bus1.signature, exp_sig[0]);
                    end
                end
            end
            if (bus2.word_valid) begin
                if (q2.size() == 0) chk("dut2 unexpected word_valid", 1, 0);
                else begin
                    e2 = q2.pop_front();
                    chk("dut2 word_out", bus2.word_out, e2.w);
                    chk("dut2 word_idx", bus2.word_idx, e2.idx);
                    chk("dut2 word cycle", cyc, e2.cyc);
                    chk("dut2 done with word", bus2.done, e2.last);
                    if (e2.last) begin
                        chk("dut2 pass", bus2.pass, exp_pass[1]);
                        chk("dut2 order_err_cnt", bus2.order_err_cnt, exp_err[1]);
                        chk("dut2 signature", bus2.signature, exp_sig[1]);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] asc[$];
        logic [7:0] errf[$];
        logic [7:0] satf[$];
        logic [7:0] ascii[$];
        int         a;

        for (int i = 0; i < 16; i++) asc.push_back(8'(i));
        errf = '{8'h05, 8'h03, 8'h03, 8'h01};
        for (int i = 0; i < 12; i++) errf.push_back(8'(8'h10 + i));
        for (int i = 0; i < 256; i++) begin satf.push_back(8'hFF); satf.push_back(8'h00); end
        for (int i = 0; i < 9; i++) ascii.push_back(8'(8'h31 + i));

        chk("model crc of 123456789", crc_bytes(ascii), 16'h29B1);
        chk("model order errs err frame", order_errs(errf), 2);
        chk("model order errs sat frame", order_errs(satf), 255);
        chk("model order errs ascending", order_errs(asc), 0);

        bus1.sort_finish = 1'b1; bus1.data_in = 1'b0;
        bus2.sort_finish = 1'b0; bus2.data_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge t_clk);
        chk("reset word_valid", bus1.word_valid, 0);
        chk("reset word_out", bus1.word_out, 0);
        chk("reset word_idx", bus1.word_idx, 0);
        chk("reset done", bus1.done, 0);
        chk("reset pass", bus1.pass, 0);
        chk("reset timeout", bus1.timeout, 0);
        chk("reset order_err_cnt", bus1.order_err_cnt, 0);
        chk("reset signature", bus1.signature, 16'hFFFF);
        chk("reset dut2 signature", bus2.signature, 16'hFFFF);

        // Level already high at release, with data toggling: must not arm.
        @(posedge t_clk);
        #1 rst_n = 1'b1;
        bus1.data_in = 1'b1;
        repeat (20) @(negedge t_clk);
        chk("no arm done", bus1.done, 0);
        chk("no arm signature", bus1.signature, 16'hFFFF);
        chk("no arm word_out", bus1.word_out, 0);

        send_frame(0, asc, -1);
        chk("asc done", bus1.done, 1);
        chk("asc pass", bus1.pass, 1);
        chk("asc signature", bus1.signature, crc_bytes(asc));

        send_frame(0, errf, -1);
        chk("errf order_err_cnt", bus1.order_err_cnt, 2);
        chk("errf done", bus1.done, 1);
        chk("errf pass", bus1.pass, 0);

        drive(0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0);
        a = cyc + 1;
        while (cyc < a + TO - 1) @(negedge t_clk);
        chk("timeout not early", bus1.timeout, 0);
        chk("timeout done not early", bus1.done, 0);
        @(negedge t_clk);
        chk("timeout flag", bus1.timeout, 1);
        chk("timeout done", bus1.done, 1);
        chk("timeout pass", bus1.pass, 0);
        chk("timeout err cleared by arm", bus1.order_err_cnt, 0);
        drive(0, 1'b0, 1'b0);
        repeat (2) @(negedge t_clk);
        chk("idle holds timeout", bus1.timeout, 1);
        chk("idle holds done", bus1.done, 1);
        drive(0, 1'b1, 1'b0);
        repeat (2) @(negedge t_clk);
        chk("rearm clears timeout", bus1.timeout, 0);
        chk("rearm clears done", bus1.done, 0);
        chk("rearm signature", bus1.signature, 16'hFFFF);
        drive(0, 1'b0, 1'b0);
        repeat (3) @(negedge t_clk);
        chk("abort in wait done", bus1.done, 0);

        send_frame(0, asc, 6 * W);
        chk("abort after word5 done", bus1.done, 0);
        chk("abort after word5 pass", bus1.pass, 0);
        send_frame(0, asc, -1);
        chk("after abort pass", bus1.pass, 1);
        chk("after abort done", bus1.done, 1);

        send_frame(0, asc, N1 * W - 1);
        chk("abort on last bit done", bus1.done, 0);
        chk("abort on last bit pass", bus1.pass, 0);

        send_frame(1, satf, -1);
        chk("sat order_err_cnt", bus2.order_err_cnt, 255);
        chk("sat done", bus2.done, 1);
        chk("sat pass", bus2.pass, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
